// File: rtl/ml_acc_pkg.sv
// Shared types and constants for the ml_acc compute core.
package ml_acc_pkg;

  localparam int DATA_W           = 32;
  localparam int ACC_W            = 64;
  localparam int WORD_STRIDE      = 4;
  localparam int START_REG_OFFSET = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_pipe.sv
// Registered signed multiply followed by a wrapping accumulate.
// A valid bit travels alongside each element through both stages.
module mac_pipe #(
  parameter int DATA_W = ml_acc_pkg::DATA_W,
  parameter int ACC_W  = ml_acc_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     busy
);

  logic                       s1_v;
  logic                       s2_v;
  logic signed [2*DATA_W-1:0] prod_q;

  // s1_v marks BRAM data present on a/b; s2_v marks prod_q holding a product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      prod_q <= '0;
      acc    <= '0;
    end else if (clear) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      prod_q <= '0;
      acc    <= '0;
    end else begin
      s1_v <= valid_in;
      s2_v <= s1_v;
      if (s1_v) prod_q <= a * b;
      if (s2_v) acc <= acc + ACC_W'(prod_q);
    end
  end

  assign busy = s1_v | s2_v;

endmodule

// File: rtl/mac_bram_engine.sv
// Dot-product engine: streams two BRAMs in lockstep through mac_pipe and
// reports a 64-bit result with a one-cycle done pulse.
module mac_bram_engine
  import ml_acc_pkg::*;
#(
  parameter int DATA_W = ml_acc_pkg::DATA_W,
  parameter int ACC_W  = ml_acc_pkg::ACC_W,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 10
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  output logic [ADDR_W-1:0] in_bram_addr,
  output logic              in_bram_en,
  input  logic [DATA_W-1:0] in_bram_dout,
  output logic [3:0]        in_bram_we,
  output logic [ADDR_W-1:0] wt_bram_addr,
  output logic              wt_bram_en,
  input  logic [DATA_W-1:0] wt_bram_dout,
  output logic [3:0]        wt_bram_we,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output state_t            state
);

  state_t                   next;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         idx;
  logic                     accept;
  logic                     last_issue;
  logic                     pipe_busy;
  logic signed [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0]        addr;

  assign accept     = (state == IDLE) && start;
  assign last_issue = (idx == len_q - LEN_W'(1));

  // A zero-length request passes through DRAIN, which sees an empty
  // pipeline and completes one cycle later.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = (vec_len == '0) ? DRAIN : FETCH;
      FETCH:   if (last_issue) next = DRAIN;
      DRAIN:   if (!pipe_busy) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= next;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      len_q  <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        len_q <= vec_len;
        idx   <= '0;
      end else if (state == FETCH) begin
        idx <= idx + LEN_W'(1);
      end
      if (state == DRAIN && !pipe_busy) result <= acc;
    end
  end

  assign addr         = (state == FETCH) ? ADDR_W'(idx) * ADDR_W'(WORD_STRIDE) : '0;
  assign in_bram_addr = addr;
  assign wt_bram_addr = addr;
  assign in_bram_en   = (state == FETCH);
  assign wt_bram_en   = (state == FETCH);
  assign in_bram_we   = 4'b0000;
  assign wt_bram_we   = 4'b0000;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  mac_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac_pipe (
    .clk      (ACLK),
    .rst      (ARESET),
    .clear    (accept),
    .valid_in (in_bram_en),
    .a        (in_bram_dout),
    .b        (wt_bram_dout),
    .acc      (acc),
    .busy     (pipe_busy)
  );

endmodule

// File: tb/tb_mac_bram_engine.sv
// Randomized scoreboard bench for mac_bram_engine with BRAM models and a
// dot-product reference computed with plain 64-bit arithmetic.
module tb_mac_bram_engine;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [9:0]  vec_len;
  logic [31:0] in_bram_addr, wt_bram_addr;
  logic        in_bram_en, wt_bram_en;
  logic [31:0] in_bram_dout, wt_bram_dout;
  logic [3:0]  in_bram_we, wt_bram_we;
  logic        busy, done;
  logic [63:0] result;
  ml_acc_pkg::state_t state;

  int          in_mem [1024];
  int          wt_mem [1024];

  logic [63:0] exp_q [$];
  int          len_q [$];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          start_cyc;
  int          exp_idx;
  bit          active   = 1'b0;
  bit          done_prev = 1'b0;

  mac_bram_engine dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .start        (start),
    .vec_len      (vec_len),
    .in_bram_addr (in_bram_addr),
    .in_bram_en   (in_bram_en),
    .in_bram_dout (in_bram_dout),
    .in_bram_we   (in_bram_we),
    .wt_bram_addr (wt_bram_addr),
    .wt_bram_en   (wt_bram_en),
    .wt_bram_dout (wt_bram_dout),
    .wt_bram_we   (wt_bram_we),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .state        (state)
  );

  // clock / cycle counter
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // BRAM models, one-cycle read latency
  always @(posedge ACLK) begin
    if (in_bram_en) in_bram_dout <= in_mem[in_bram_addr[11:2]];
    if (wt_bram_en) wt_bram_dout <= wt_mem[wt_bram_addr[11:2]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge ACLK) begin
    if (!ARESET) begin
      check("busy", {63'd0, busy}, {63'd0, active});
      check("we_zero", {56'd0, in_bram_we, wt_bram_we}, 64'd0);
      if (in_bram_en || wt_bram_en) begin
        check("en_lockstep", {63'd0, wt_bram_en}, {63'd0, in_bram_en});
        check("in_addr", {32'd0, in_bram_addr}, 64'(exp_idx * 4));
        check("wt_addr", {32'd0, wt_bram_addr}, 64'(exp_idx * 4));
        exp_idx++;
      end
      if (done) begin
        check("done_pulse_width", {63'd0, done_prev}, 64'd0);
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: done=1 with no pending request (cycle %0d)", cyc);
        end else begin
          logic [63:0] e;
          int          l;
          e = exp_q.pop_front();
          l = len_q.pop_front();
          check("result", result, e);
          check("latency", 64'(cyc - start_cyc), 64'((l == 0) ? 1 : l + 3));
          check("en_count", 64'(exp_idx), 64'(l));
        end
        active = 1'b0;
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    while (active && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    if (active) begin
      failures++;
      $display("FAIL timeout: no done within %0d cycles", n);
      active = 1'b0;
      exp_q.delete();
      len_q.delete();
    end
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      in_mem[i] = int'($urandom);
      wt_mem[i] = int'($urandom);
    end
  endtask

  task automatic fill_const(input int len, input int a, input int b);
    for (int i = 0; i < len; i++) begin
      in_mem[i] = a;
      wt_mem[i] = b;
    end
  endtask

  task automatic issue(input int len);
    longint sum = 0;
    for (int i = 0; i < len; i++) sum += longint'(in_mem[i]) * longint'(wt_mem[i]);
    exp_q.push_back(64'(sum));
    len_q.push_back(len);
    @(negedge ACLK);
    vec_len = 10'(len);
    start   = 1'b1;
    @(posedge ACLK);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    exp_idx   = 0;
    active    = 1'b1;
    vec_len   = 10'($urandom);
  endtask

  task automatic run_op(input int len, input bit disturb);
    issue(len);
    if (disturb) begin
      repeat ($urandom_range(1, 2)) @(negedge ACLK);
      vec_len = 10'($urandom_range(1, 1023));
      start   = 1'b1;
      @(posedge ACLK);
      #1 start = 1'b0;
    end
    wait_idle();
    repeat ($urandom_range(0, 3)) @(negedge ACLK);
  endtask

  initial begin
    ARESET  = 1'b1;
    start   = 1'b0;
    vec_len = '0;
    repeat (3) @(negedge ACLK);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_en", {62'd0, in_bram_en, wt_bram_en}, 64'd0);
    check("reset_addr", {in_bram_addr, wt_bram_addr}, 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);

    fill_const(1, -5, 3);
    run_op(1, 1'b0);
    fill_const(4, 1, 1);
    run_op(4, 1'b0);
    for (int i = 0; i < 25; i++) begin
      in_mem[i] = -2 * i * i * i + 30 * i * i + 231;
      wt_mem[i] = -(i * i * i) + 3 * i * i + 129;
    end
    run_op(25, 1'b0);
    run_op(0, 1'b0);
    fill_const(4, 32'h8000_0000, 32'h8000_0000);
    run_op(4, 1'b0);
    fill_random(20);
    run_op(20, 1'b1);

    // start held across the DONE -> IDLE edge must not launch a run
    fill_random(6);
    issue(6);
    begin
      int n = 0;
      while (!done && n < 100) begin
        @(negedge ACLK);
        n++;
      end
    end
    start   = 1'b1;
    vec_len = 10'd5;
    @(posedge ACLK);
    #1 start = 1'b0;
    wait_idle();
    repeat (6) @(negedge ACLK);

    // reset in the middle of FETCH aborts everything
    fill_random(30);
    issue(30);
    repeat (8) @(negedge ACLK);
    #2 ARESET = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_en", {62'd0, in_bram_en, wt_bram_en}, 64'd0);
    exp_q.delete();
    len_q.delete();
    active = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    fill_random(9);
    run_op(9, 1'b0);

    for (int k = 0; k < 12; k++) begin
      int l;
      l = $urandom_range(0, 48);
      fill_random(l);
      run_op(l, 1'($urandom_range(0, 1)));
    end
    fill_random(1023);
    run_op(1023, 1'b1);

    repeat (3) @(negedge ACLK);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d expected results never produced", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
